// File: rtl/router_rc_pipe_pkg.sv
// Shared NoC definitions for the route-compute pipeline stage: output port codes,
// wormhole lock FSM states and routing-order selectors.
package router_rc_pipe_pkg;

  typedef enum logic [2:0] {
    PORT_EMPTY = 3'd0,
    PORT_LOCAL = 3'd1,
    PORT_X1    = 3'd2,  // towards x-1
    PORT_X2    = 3'd3,  // towards x+1
    PORT_Y1    = 3'd4,  // towards y-1
    PORT_Y2    = 3'd5   // towards y+1
  } port_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int MODE_XY = 0;
  localparam int MODE_YX = 1;

endpackage

// File: rtl/router_rc_pipe_if.sv
// Flit input / routed-flit output handshake bundle of the route-compute stage.
interface router_rc_pipe_if #(
  parameter int X_W = 2,
  parameter int Y_W = 1
) ();

  logic           in_valid;
  logic           in_ready;
  logic           in_head;
  logic           in_tail;
  logic [X_W-1:0] dst_x;
  logic [Y_W-1:0] dst_y;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_port;
  logic           out_head;
  logic           out_tail;
  logic           out_err;

  // Router side
  modport slave (
    input  in_valid, in_head, in_tail, dst_x, dst_y, out_ready,
    output in_ready, out_valid, out_port, out_head, out_tail, out_err
  );

  // Upstream source plus downstream sink side
  modport master (
    output in_valid, in_head, in_tail, dst_x, dst_y, out_ready,
    input  in_ready, out_valid, out_port, out_head, out_tail, out_err
  );

endinterface

// File: rtl/router_rc_calc.sv
// Combinational dimension-ordered route computation for a 2D mesh router,
// flagging destinations that lie outside the mesh.
module router_rc_calc
  import router_rc_pipe_pkg::*;
#(
  parameter int NUM_X = 4,
  parameter int NUM_Y = 2,
  parameter int X_W   = 2,
  parameter int Y_W   = 1,
  parameter int MODE  = MODE_XY
) (
  input  logic [X_W-1:0] i_cur_x,
  input  logic [Y_W-1:0] i_cur_y,
  input  logic [X_W-1:0] i_dst_x,
  input  logic [Y_W-1:0] i_dst_y,
  output port_e          o_port,
  output logic           o_err
);

  port_e w_x_port;
  port_e w_y_port;
  logic  w_x_diff;
  logic  w_y_diff;

  assign w_x_diff = (i_dst_x != i_cur_x);
  assign w_y_diff = (i_dst_y != i_cur_y);
  assign w_x_port = (i_dst_x > i_cur_x) ? PORT_X2 : PORT_X1;
  assign w_y_port = (i_dst_y > i_cur_y) ? PORT_Y2 : PORT_Y1;

  // Widened so the range test is exact even when the mesh fills the coordinate space.
  assign o_err = (32'(i_dst_x) >= 32'(NUM_X)) || (32'(i_dst_y) >= 32'(NUM_Y));

  always_comb begin
    o_port = PORT_LOCAL;
    if (o_err) begin
      o_port = PORT_EMPTY;
    end else if (MODE == MODE_YX) begin
      if (w_y_diff)      o_port = w_y_port;
      else if (w_x_diff) o_port = w_x_port;
    end else begin
      if (w_x_diff)      o_port = w_x_port;
      else if (w_y_diff) o_port = w_y_port;
    end
  end

endmodule

// File: rtl/router_rc_pipe.sv
// Route-compute pipeline stage: routes head flits, locks the port for the body of
// a wormhole packet and presents one registered flit behind a valid/ready handshake.
module router_rc_pipe
  import router_rc_pipe_pkg::*;
#(
  parameter int NUM_X = 4,
  parameter int NUM_Y = 2,
  parameter int X_W   = 2,
  parameter int Y_W   = 1,
  parameter int MODE  = MODE_XY
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [X_W-1:0] router_x,
  input  logic [Y_W-1:0] router_y,
  router_rc_pipe_if.slave bus
);

  state_e r_state, w_state_nxt;
  port_e  r_lock_port, w_lock_port_nxt;
  logic   r_lock_err, w_lock_err_nxt;
  port_e  w_calc_port;
  logic   w_calc_err;
  port_e  w_out_port_nxt;
  logic   w_out_err_nxt;
  logic   w_fire;

  logic   r_out_valid;
  port_e  r_out_port;
  logic   r_out_head;
  logic   r_out_tail;
  logic   r_out_err;

  router_rc_calc #(
    .NUM_X(NUM_X), .NUM_Y(NUM_Y), .X_W(X_W), .Y_W(Y_W), .MODE(MODE)
  ) u_calc (
    .i_cur_x (router_x),
    .i_cur_y (router_y),
    .i_dst_x (bus.dst_x),
    .i_dst_y (bus.dst_y),
    .o_port  (w_calc_port),
    .o_err   (w_calc_err)
  );

  assign bus.in_ready = en && (!r_out_valid || bus.out_ready);
  assign w_fire       = bus.in_valid && bus.in_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_lock_port_nxt = r_lock_port;
    w_lock_err_nxt  = r_lock_err;
    w_out_port_nxt  = PORT_EMPTY;
    w_out_err_nxt   = 1'b1;
    if (w_fire) begin
      if (bus.in_head) begin
        // A head inside a locked packet means the previous tail was lost.
        w_out_port_nxt  = w_calc_port;
        w_out_err_nxt   = w_calc_err || (r_state == ST_LOCKED);
        w_lock_port_nxt = w_calc_port;
        w_lock_err_nxt  = w_calc_err;
        w_state_nxt     = bus.in_tail ? ST_IDLE : ST_LOCKED;
      end else if (r_state == ST_LOCKED) begin
        w_out_port_nxt = r_lock_port;
        w_out_err_nxt  = r_lock_err;
        if (bus.in_tail) w_state_nxt = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lock_port <= PORT_EMPTY;
      r_lock_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_port <= w_lock_port_nxt;
      r_lock_err  <= w_lock_err_nxt;
    end
  end

  // NOTE: the output payload is reset along with valid, so no stale route is visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_port  <= PORT_EMPTY;
      r_out_head  <= 1'b0;
      r_out_tail  <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_port  <= w_out_port_nxt;
      r_out_head  <= bus.in_head;
      r_out_tail  <= bus.in_tail;
      r_out_err   <= w_out_err_nxt;
    end else if (en && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_port  = r_out_port;
  assign bus.out_head  = r_out_head;
  assign bus.out_tail  = r_out_tail;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_router_rc_pipe.sv
// Scoreboard bench: two stages at router (1,0) of a 4x2 mesh (XY with 2-bit y,
// YX with 1-bit y) share one stimulus stream and are checked against a packet model.
module tb_router_rc_pipe;
  import router_rc_pipe_pkg::*;

  localparam int RX = 1;
  localparam int RY = 0;

  typedef struct {
    int port;
    bit err;
    bit head;
    bit tail;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d_valid, d_head, d_tail, d_ready;
  logic [1:0] d_dx, d_dy;
  bit         rnd_mode = 1'b0;

  int tests = 0;
  int fails = 0;

  beat_t qa[$];
  beat_t qb[$];
  bit    lk[2];
  int    lp[2];
  bit    le[2];

  always #5 clk = ~clk;

  router_rc_pipe_if #(.X_W(2), .Y_W(2)) bus_a ();
  router_rc_pipe_if #(.X_W(2), .Y_W(1)) bus_b ();

  assign bus_a.in_valid  = d_valid;
  assign bus_a.in_head   = d_head;
  assign bus_a.in_tail   = d_tail;
  assign bus_a.dst_x     = d_dx;
  assign bus_a.dst_y     = d_dy;
  assign bus_a.out_ready = d_ready;
  assign bus_b.in_valid  = d_valid;
  assign bus_b.in_head   = d_head;
  assign bus_b.in_tail   = d_tail;
  assign bus_b.dst_x     = d_dx;
  assign bus_b.dst_y     = d_dy[0];
  assign bus_b.out_ready = d_ready;

  router_rc_pipe #(.NUM_X(4), .NUM_Y(2), .X_W(2), .Y_W(2), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .router_x(2'd1), .router_y(2'd0), .bus(bus_a)
  );

  router_rc_pipe #(.NUM_X(4), .NUM_Y(2), .X_W(2), .Y_W(1), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .router_x(2'd1), .router_y(1'b0), .bus(bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Dimension-ordered routing on a 4x2 mesh seen from (RX,RY).
  task automatic route(input int mode, input int dx, input int dy, output int port, output bit err);
    int hx, hy;
    err = (dx >= 4) || (dy >= 2);
    hx  = (dx > RX) ? 3 : 2;
    hy  = (dy > RY) ? 5 : 4;
    if (err)                         port = 0;
    else if (dx == RX && dy == RY)   port = 1;
    else if (mode == 0)              port = (dx != RX) ? hx : hy;
    else                             port = (dy != RY) ? hy : hx;
  endtask

  task automatic model_step(input int id, input int mode, input bit h, input bit t,
                            input int dx, input int dy, output beat_t b);
    int p;
    bit e;
    b.head = h;
    b.tail = t;
    if (h) begin
      route(mode, dx, dy, p, e);
      b.port = p;
      b.err  = e | lk[id];
      lk[id] = !t;
      lp[id] = p;
      le[id] = e;
    end else if (lk[id]) begin
      b.port = lp[id];
      b.err  = le[id];
      if (t) lk[id] = 1'b0;
    end else begin
      b.port = 0;
      b.err  = 1'b1;
    end
  endtask

  task automatic cmp_beat(input string tag, input beat_t e, input logic [2:0] port,
                          input logic err, input logic head, input logic tail);
    check({tag, ".out_port"}, 32'(port), 32'(e.port));
    check({tag, ".out_err"},  32'(err),  32'(e.err));
    check({tag, ".out_head"}, 32'(head), 32'(e.head));
    check({tag, ".out_tail"}, 32'(tail), 32'(e.tail));
  endtask

  // Monitor + model: evaluated mid-cycle, describing what the next rising edge does.
  always @(negedge clk) begin
    bit    exp_v, cons, fire;
    beat_t ba, bb;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      lk[0] = 1'b0;
      lk[1] = 1'b0;
    end else begin
      exp_v = (qa.size() != 0);
      check("a.out_valid", 32'(bus_a.out_valid), 32'(exp_v));
      check("b.out_valid", 32'(bus_b.out_valid), 32'(exp_v));
      check("a.in_ready", 32'(bus_a.in_ready), 32'(en && (!exp_v || d_ready)));
      check("b.in_ready", 32'(bus_b.in_ready), 32'(en && (!exp_v || d_ready)));
      if (exp_v) begin
        cmp_beat("a", qa[0], bus_a.out_port, bus_a.out_err, bus_a.out_head, bus_a.out_tail);
        cmp_beat("b", qb[0], bus_b.out_port, bus_b.out_err, bus_b.out_head, bus_b.out_tail);
      end
      cons = en && d_ready && exp_v;
      fire = en && d_valid && (!exp_v || d_ready);
      if (cons) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (fire) begin
        model_step(0, 0, d_head, d_tail, int'(d_dx), int'(d_dy), ba);
        model_step(1, 1, d_head, d_tail, int'(d_dx), int'(d_dy[0]), bb);
        qa.push_back(ba);
        qb.push_back(bb);
      end
    end
  end

  task automatic randomize_ctrl();
    if (rnd_mode) begin
      d_ready = ($urandom_range(0, 3) != 0);
      en      = ($urandom_range(0, 7) != 0);
    end
  endtask

  // Called and returning at posedge+1; returns once the flit has been accepted.
  task automatic send(input bit h, input bit t, input int dx, input int dy);
    bit got = 1'b0;
    d_valid = 1'b1;
    d_head  = h;
    d_tail  = t;
    d_dx    = 2'(dx);
    d_dy    = 2'(dy);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      randomize_ctrl();
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no in_ready expected accept within 200 cycles");
    end
    d_valid = 1'b0;
    randomize_ctrl();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      randomize_ctrl();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; en = 1'b1; d_ready = 1'b1;
    d_valid = 1'b0; d_head = 1'b0; d_tail = 1'b0; d_dx = '0; d_dy = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 32'(bus_a.out_valid), 0);
    check("rst.out_port",  32'(bus_a.out_port),  0);
    check("rst.out_head",  32'(bus_a.out_head),  0);
    check("rst.out_tail",  32'(bus_a.out_tail),  0);
    check("rst.out_err",   32'(bus_a.out_err),   0);
    check("rst.b.out_valid", 32'(bus_b.out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Single-flit packets: XY and YX orders
    send(1, 1, 3, 1);
    check("xy(3,1).port", 32'(bus_a.out_port), 3);
    check("xy(3,1).err",  32'(bus_a.out_err),  0);
    check("yx(3,1).port", 32'(bus_b.out_port), 5);
    send(1, 1, 1, 0);
    check("yx(1,0).port", 32'(bus_b.out_port), 1);
    send(1, 1, 0, 0);
    check("yx(0,0).port", 32'(bus_b.out_port), 2);
    idle(2);

    // 4-flit packet with a 3-cycle downstream stall while flit 2 is presented
    send(1, 0, 1, 1);
    send(0, 0, 1, 1);
    d_ready = 1'b0;
    d_valid = 1'b1; d_head = 1'b0; d_tail = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall.in_ready", 32'(bus_a.in_ready), 0);
      check("stall.port",     32'(bus_a.out_port), 5);
      check("stall.b.port",   32'(bus_b.out_port), 5);
      @(posedge clk);
      #1;
    end
    d_ready = 1'b1;
    send(0, 0, 1, 1);
    send(0, 1, 1, 1);
    check("tail.port", 32'(bus_a.out_port), 5);
    send(0, 0, 0, 0);
    check("after_tail.port", 32'(bus_a.out_port), 0);
    check("after_tail.err",  32'(bus_a.out_err),  1);
    idle(2);

    // Out-of-range head locks an error for the whole packet
    send(1, 0, 2, 3);
    check("oor_head.port", 32'(bus_a.out_port), 0);
    check("oor_head.err",  32'(bus_a.out_err),  1);
    send(0, 0, 0, 0);
    check("oor_body.err",  32'(bus_a.out_err),  1);
    send(0, 1, 0, 0);
    check("oor_tail.err",  32'(bus_a.out_err),  1);
    idle(2);

    // Reset in the middle of a packet discards the lock
    send(1, 0, 3, 0);
    check("pre_rst.port", 32'(bus_a.out_port), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(bus_a.out_valid), 0);
    check("mid_rst.out_port",  32'(bus_a.out_port),  0);
    check("mid_rst.out_head",  32'(bus_a.out_head),  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    send(0, 1, 3, 0);
    check("post_rst_body.port", 32'(bus_a.out_port), 0);
    check("post_rst_body.err",  32'(bus_a.out_err),  1);
    idle(2);

    // Stage disabled with a flit pending: everything frozen
    send(1, 1, 0, 1);
    en = 1'b0;
    d_valid = 1'b1; d_head = 1'b1; d_tail = 1'b1; d_dx = 2'd3; d_dy = 2'd0;
    repeat (5) begin
      @(negedge clk);
      check("en_low.in_ready",  32'(bus_a.in_ready),  0);
      check("en_low.out_valid", 32'(bus_a.out_valid), 1);
      check("en_low.port",      32'(bus_a.out_port),  2);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    send(1, 1, 3, 0);
    idle(2);

    // Randomized traffic with random backpressure and enable
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 3)));
      if (i == 200) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    rnd_mode = 1'b0;
    en = 1'b1;
    d_ready = 1'b1;
    idle(5);
    check("drain.out_valid", 32'(bus_a.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
